arbitro_rr_fifos: RTL and testbench

Four-input word arbiter that sits between the four ingress FIFOs (0–3) and the four egress FIFOs (4–7) of the FIFO switching module. Each cycle it picks one non-empty ingress FIFO whose head word can be accepted and pops it. It forwards that word, registered, to the egress FIFO selected by the word's two MSBs. Ingress FIFOs are first-word-fall-through: the head word is valid whenever the FIFO is not empty.

---
 rtl/arbitro_rr_fifos_if.sv | 31 +++
 rtl/arbitro_rr_fifos.sv | 109 ++++++++++
 tb/tb_arbitro_rr_fifos.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/arbitro_rr_fifos_if.sv
// Port bundle between the word arbiter and its four ingress / four egress FIFOs.
// master = arbiter side, slave = FIFO/environment side.
interface arbitro_rr_fifos_if #(
    parameter int data_width = 10
);
    // Handshake: an ingress head word is valid whenever its fifo_empty bit is 0;
    // pop[i] is the ready that consumes it in the same cycle. push[j] is the
    // egress valid and carries data_out; the egress side has no ready and instead
    // raises almost_full[j] early enough to absorb the one word in flight.
    logic [3:0]            fifo_empty;
    logic [data_width-1:0] fifo_data0;
    logic [data_width-1:0] fifo_data1;
    logic [data_width-1:0] fifo_data2;
    logic [data_width-1:0] fifo_data3;
    logic [3:0]            almost_full;
    logic [3:0]            pop;
    logic [3:0]            push;
    logic [data_width-1:0] data_out;
    logic [1:0]            grant;
    logic [1:0]            arb_state;

    modport master (
        input  fifo_empty, fifo_data0, fifo_data1, fifo_data2, fifo_data3, almost_full,
        output pop, push, data_out, grant, arb_state
    );

    modport slave (
        output fifo_empty, fifo_data0, fifo_data1, fifo_data2, fifo_data3, almost_full,
        input  pop, push, data_out, grant, arb_state
    );
endinterface

// File: rtl/arbitro_rr_fifos.sv
// Four-input round-robin word arbiter from ingress FIFOs 0-3 to egress FIFOs 4-7.
// Define ARB_STRICT_PRIO_EN for fixed priority 0 > 1 > 2 > 3 instead of round-robin.
module arbitro_rr_fifos #(
    parameter int data_width = 10
) (
    input  logic               clk,
    input  logic               reset,
    arbitro_rr_fifos_if.master bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE   = 2'd1,
        BLOCKED = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [1:0]            ptr_q, ptr_d;
    logic [3:0]            push_q, push_d;
    logic [data_width-1:0] data_q, data_d;
    logic [1:0]            grant_q, grant_d;

    logic [data_width-1:0] head [4];
    logic [1:0]            dest [4];
    logic [3:0]            eligible;
    logic                  found;
    logic [1:0]            win;
    logic [1:0]            idx;

    always_comb begin
        head[0] = bus.fifo_data0;
        head[1] = bus.fifo_data1;
        head[2] = bus.fifo_data2;
        head[3] = bus.fifo_data3;
        for (int i = 0; i < 4; i++) begin
            dest[i]     = head[i][data_width-1 -: 2];
            eligible[i] = !bus.fifo_empty[i] && !bus.almost_full[dest[i]];
        end
    end

    // First eligible index starting at ptr_q; 2-bit index arithmetic wraps 3 -> 0.
    always_comb begin
        found = 1'b0;
        win   = 2'd0;
        idx   = 2'd0;
        for (int k = 0; k < 4; k++) begin
            idx = ptr_q + 2'(k);
            if (!found && eligible[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    assign bus.pop = (found && !reset) ? (4'b0001 << win) : 4'b0000;

    always_comb begin
        push_d  = 4'b0000;
        data_d  = data_q;
        grant_d = grant_q;
        if (found) begin
            push_d  = 4'b0001 << dest[win];
            data_d  = head[win];
            grant_d = win;
        end
    end

    always_comb begin
`ifdef ARB_STRICT_PRIO_EN
        ptr_d = 2'd0;
`else
        ptr_d = found ? (win + 2'd1) : ptr_q;
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            push_q  <= 4'b0000;
            data_q  <= '0;
            grant_q <= 2'd0;
            ptr_q   <= 2'd0;
        end else begin
            push_q  <= push_d;
            data_q  <= data_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        if (found)                 state_d = SERVE;
        else if (!(&bus.fifo_empty)) state_d = BLOCKED;
        else                       state_d = IDLE;
    end

    always_comb begin
        bus.arb_state = state_q;
    end

    assign bus.push     = push_q;
    assign bus.data_out = data_q;
    assign bus.grant    = grant_q;

endmodule

// File: tb/tb_arbitro_rr_fifos.sv
// Bench for arbitro_rr_fifos: ingress FIFOs modelled as arrays, arbitration
// rules applied per cycle, plus directed scenarios pinned with literal values.
module tb_arbitro_rr_fifos;
  localparam int W = 10;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  arbitro_rr_fifos_if #(.data_width(W)) bus ();
  arbitro_rr_fifos #(.data_width(W)) dut (.clk(clk), .reset(reset), .bus(bus));

  int tests = 0;
  int fails = 0;

  logic [W-1:0] mem [4][64];
  int           rd [4];
  int           wr [4];
  logic [3:0]   af;

  int           m_ptr;
  logic [3:0]   exp_push;
  logic [W-1:0] exp_data;
  logic [1:0]   exp_grant;
  logic [1:0]   exp_state;
  logic [W-1:0] exp_q[$];
  logic [3:0]   last_pop;
  int           dlog[$];
  int           order_exp [12];
  int           wrap_exp [4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int fsize(input int i);
    return wr[i] - rd[i];
  endfunction

  task automatic put(input int i, input logic [W-1:0] word);
    mem[i][wr[i] % 64] = word;
    wr[i]++;
  endtask

  task automatic clear_fifos();
    for (int i = 0; i < 4; i++) begin
      rd[i] = 0;
      wr[i] = 0;
    end
  endtask

  task automatic drive_inputs();
    logic [W-1:0] d [4];
    for (int i = 0; i < 4; i++) begin
      bus.fifo_empty[i] = (fsize(i) == 0);
      d[i] = (fsize(i) > 0) ? mem[i][rd[i] % 64] : W'($urandom);
    end
    bus.fifo_data0  = d[0];
    bus.fifo_data1  = d[1];
    bus.fifo_data2  = d[2];
    bus.fifo_data3  = d[3];
    bus.almost_full = af;
  endtask

  // One cycle: called at posedge+1, returns at the next posedge+1.
  task automatic step();
    int w;
    logic [W-1:0] word;
    logic [1:0] dd;
    bit any_ne;
    drive_inputs();
    #1;
    w = -1;
    any_ne = 0;
    for (int k = 0; k < 4; k++) begin
      int i;
      i = (m_ptr + k) % 4;
      if (fsize(i) > 0) begin
        any_ne = 1;
        word = mem[i][rd[i] % 64];
        dd = word[W-1 -: 2];
        if (w < 0 && !af[dd]) w = i;
      end
    end
    last_pop = bus.pop;
    check("pop", {28'd0, bus.pop}, (w >= 0) ? (32'd1 << w) : 32'd0);
    @(posedge clk);
    #1;
    if (w >= 0) begin
      word = mem[w][rd[w] % 64];
      rd[w]++;
      exp_q.push_back(word);
      dd = word[W-1 -: 2];
      exp_push  = 4'(1 << dd);
      exp_grant = 2'(w);
      exp_state = 2'd1;
`ifdef ARB_STRICT_PRIO_EN
      m_ptr = 0;
`else
      m_ptr = (w + 1) % 4;
`endif
      exp_data = exp_q.pop_front();
    end else begin
      exp_push  = 4'b0000;
      exp_state = any_ne ? 2'd2 : 2'd0;
    end
    check("push", {28'd0, bus.push}, {28'd0, exp_push});
    check("data_out", {22'd0, bus.data_out}, {22'd0, exp_data});
    check("grant", {30'd0, bus.grant}, {30'd0, exp_grant});
    check("arb_state", {30'd0, bus.arb_state}, {30'd0, exp_state});
    if (bus.push != 4'b0000) dlog.push_back(int'(bus.grant));
  endtask

  // Asynchronous reset asserted between edges, held over one edge.
  task automatic do_reset();
    #2 reset = 1'b1;
    #1;
    check("rst_push", {28'd0, bus.push}, 32'd0);
    check("rst_pop", {28'd0, bus.pop}, 32'd0);
    check("rst_data", {22'd0, bus.data_out}, 32'd0);
    check("rst_state", {30'd0, bus.arb_state}, 32'd0);
    m_ptr = 0;
    exp_push = 4'b0000;
    exp_data = '0;
    exp_grant = 2'd0;
    exp_state = 2'd0;
    exp_q.delete();
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic drain(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  initial begin
`ifdef ARB_STRICT_PRIO_EN
    order_exp = '{0, 0, 0, 1, 1, 1, 2, 2, 2, 3, 3, 3};
    wrap_exp  = '{0, 0, 3, 3};
`else
    order_exp = '{0, 1, 2, 3, 0, 1, 2, 3, 0, 1, 2, 3};
    wrap_exp  = '{3, 0, 3, 0};
`endif
    reset = 1'b1;
    af = 4'b0000;
    m_ptr = 0;
    exp_push = 4'b0000;
    exp_data = '0;
    exp_grant = 2'd0;
    exp_state = 2'd0;
    clear_fifos();

    // Reset state, with a non-empty input to show pop is gated.
    put(0, 10'h101);
    drive_inputs();
    #1;
    check("init_pop", {28'd0, bus.pop}, 32'd0);
    check("init_push", {28'd0, bus.push}, 32'd0);
    check("init_data", {22'd0, bus.data_out}, 32'd0);
    check("init_grant", {30'd0, bus.grant}, 32'd0);
    check("init_state", {30'd0, bus.arb_state}, 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;

    // Single word.
    step();
    check("sw_pop", {28'd0, last_pop}, 32'h1);
    check("sw_push", {28'd0, bus.push}, 32'h2);
    check("sw_data", {22'd0, bus.data_out}, 32'h101);
    check("sw_grant", {30'd0, bus.grant}, 32'd0);
    check("sw_state", {30'd0, bus.arb_state}, 32'd1);
    step();
    check("sw_idle", {30'd0, bus.arb_state}, 32'd0);

    // Fairness: 3 words per input, distinct destinations.
    do_reset();
    clear_fifos();
    for (int j = 0; j < 3; j++)
      for (int i = 0; i < 4; i++) put(i, {2'(i), 8'(j * 16 + i)});
    dlog.delete();
    drain(12);
    check("fair_count", dlog.size(), 32'd12);
    for (int k = 0; k < 12; k++)
      if (k < dlog.size()) check("fair_order", dlog[k], order_exp[k]);
    drain(1);

    // Skip on almost_full.
    do_reset();
    clear_fifos();
    put(0, {2'd2, 8'h20});
    put(1, {2'd3, 8'h31});
    put(1, {2'd3, 8'h32});
    af = 4'b0100;
    step();
    check("skip_pop", {28'd0, last_pop}, 32'h2);
    af = 4'b0000;
    step();
    check("skip_release_pop", {28'd0, last_pop}, 32'h1);
    drain(3);

    // Blocked: every head targets a full destination.
    for (int i = 0; i < 4; i++) put(i, {2'd0, 8'(8'h40 + i)});
    af = 4'b0001;
    step();
    check("blk_pop", {28'd0, last_pop}, 32'd0);
    check("blk_push", {28'd0, bus.push}, 32'd0);
    check("blk_state", {30'd0, bus.arb_state}, 32'd2);
    step();
    af = 4'b0000;
    drain(5);

    // Reset while a push is in flight.
    for (int i = 0; i < 4; i++) begin
      put(i, {2'(3 - i), 8'(8'h50 + i)});
      put(i, {2'(3 - i), 8'(8'h60 + i)});
    end
    step();
    check("mid_push_pending", {31'd0, bus.push != 4'b0000}, 32'd1);
    do_reset();
    step();
    check("post_rst_pop", {28'd0, last_pop}, 32'h1);
    drain(8);

    // Wrap-around: ptr at 3 with inputs 3 and 0 eligible.
    do_reset();
    clear_fifos();
    put(2, {2'd2, 8'h70});
    step();
    put(3, {2'd3, 8'h71});
    put(3, {2'd3, 8'h72});
    put(0, {2'd0, 8'h73});
    put(0, {2'd0, 8'h74});
    dlog.delete();
    drain(4);
    check("wrap_count", dlog.size(), 32'd4);
    for (int k = 0; k < 4; k++)
      if (k < dlog.size()) check("wrap_order", dlog[k], wrap_exp[k]);
    drain(1);

    // Randomized traffic.
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < 4; i++)
        if (fsize(i) < 6 && $urandom_range(0, 1) == 1) put(i, W'($urandom));
      af = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0000;
      step();
    end
    af = 4'b0000;
    drain(30);
    for (int i = 0; i < 4; i++) check("drained", fsize(i), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
